ab_seq_gen: RTL

Stimulus generator for the same-value/hold detector protocol. It takes a stream of desired detector output bits and drives the A/B input pair that forces the detector to produce exactly that bit sequence. It also presents a cycle-aligned expected-output stream for scoreboarding. It sits between a test/traffic source and the detector's A/B inputs.

---
 rtl/ab_seq_gen.sv | 95 +++++++++
 1 files changed

// File: rtl/ab_seq_gen.sv
// A/B stimulus generator for the same-value/hold detector. It pops desired output bits
// from a small FIFO and drives the A/B pair that makes the detector produce them.
module ab_seq_gen #(
  parameter int DEPTH       = 4,
  parameter bit PREFER_HOLD = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic                       req_bit,
  output logic                       req_ready,
  output logic                       a,
  output logic                       b,
  output logic                       gen_valid,
  output logic                       exp_o,
  output logic                       exp_valid,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  // Detector model state: {a_prev, o_prev}. The a output is the a_prev bit itself.
  typedef enum logic [1:0] {
    A0O0 = 2'b00,
    A0O1 = 2'b01,
    A1O0 = 2'b10,
    A1O1 = 2'b11
  } state_t;

  state_t          state, state_next;
  logic [DEPTH-1:0] mem;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, d;
  logic            a_prev, o_prev;
  logic            a_next, b_next, o_next;

  // Handshake: a request transfers on a posedge where req_valid && req_ready.
  // req_ready comes only from the registered level, never from req_valid.
  assign req_ready = (level != LW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (level != '0);
  assign d         = mem[rd_ptr];
  assign a_prev    = state[1];
  assign o_prev    = state[0];
  assign a         = a_prev;

  always_comb begin
    a_next = a_prev;
    b_next = 1'b0;
    if (pop) begin
      if (!d) begin
        a_next = ~a_prev;
      end else if (PREFER_HOLD && o_prev) begin
        a_next = ~a_prev;
        b_next = 1'b1;
      end
    end
    // Same detector equation runs on idle cycles too, so o_prev tracks the real detector.
    o_next     = (a_next == a_prev) | (b_next & o_prev);
    state_next = state_t'({a_next, o_next});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= A0O0;
      b         <= 1'b0;
      gen_valid <= 1'b0;
      exp_o     <= 1'b0;
      exp_valid <= 1'b0;
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state     <= state_next;
      b         <= b_next;
      gen_valid <= pop;
      exp_o     <= o_prev;
      exp_valid <= gen_valid;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= req_bit;
  end

endmodule
